// File: rtl/pc_branch_unit.sv
// Fetch PC generator with taken-branch redirect and a one-cycle wrong-path flush.
// A taken branch redirects pc and raises flush for one cycle (longer while stall is held).
// A branch decision that arrives while flushing is ignored.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pc_src,
  input  logic [31:0]        branch_pc,
  input  logic [31:0]        branch_offset,
  input  logic               stall,
  output logic [31:0]        pc,
  output logic               flush,
  output logic [COUNT_W-1:0] taken_count
);

  localparam logic [0:0] StRun   = 1'b0;
  localparam logic [0:0] StFlush = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic [31:0] offset_bytes;
  logic [31:0] target;
  logic [31:0] pc_seq;
  logic        count_sat;

  // Redirect target, sequential address and counter saturation flag.
  always_comb begin
    offset_bytes = branch_offset << 2;
    target       = (branch_pc + 32'd4 + offset_bytes) & 32'hFFFF_FFFC;
    pc_seq       = pc_q + 32'd4;
    count_sat    = &count_q;
  end

  // Next-state logic: a branch in RUN beats stall; FLUSH ignores pc_src.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    case (state_q)
      StRun: begin
        if (pc_src) begin
          pc_d    = target;
          state_d = StFlush;
          if (!count_sat) begin
            count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
          end
        end else if (!stall) begin
          pc_d = pc_seq;
        end
      end
      StFlush: begin
        if (!stall) begin
          pc_d    = pc_seq;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // flush is the registered FLUSH state bit itself.
  always_comb begin
    pc          = pc_q;
    flush       = (state_q == StFlush);
    taken_count = count_q;
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: a behavioural model pushes the expected
// post-edge outputs when stimulus is driven; each test pops and compares after the edge.
module tb_pc_branch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic        pc_src;
  logic [31:0] branch_pc;
  logic [31:0] branch_offset;
  logic        stall;
  logic [31:0] pc;
  logic        flush;
  logic [1:0]  taken_count;

  typedef struct packed {
    logic [31:0] pc;
    logic        flush;
    logic [1:0]  cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  logic [31:0] m_pc;
  logic        m_flush;
  logic [1:0]  m_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pc_branch_unit #(
    .RESET_PC (RESET_PC),
    .COUNT_W  (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pc_src        (pc_src),
    .branch_pc     (branch_pc),
    .branch_offset (branch_offset),
    .stall         (stall),
    .pc            (pc),
    .flush         (flush),
    .taken_count   (taken_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_flush = 1'b0;
    m_cnt   = 2'd0;
    sb.delete();
  endtask

  // Drive one cycle of inputs, push the modelled result, and advance to just past the edge.
  task automatic drive_cycle(input logic st, input logic src, input logic [31:0] bpc,
                             input logic [31:0] boff);
    exp_t e;
    stall         = st;
    pc_src        = src;
    branch_pc     = bpc;
    branch_offset = boff;
    if (!m_flush) begin
      if (src) begin
        m_pc    = (bpc + 32'd4 + boff * 32'd4) & 32'hFFFF_FFFC;
        m_flush = 1'b1;
        if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
      end else if (!st) begin
        m_pc = m_pc + 32'd4;
      end
    end else if (!st) begin
      m_pc    = m_pc + 32'd4;
      m_flush = 1'b0;
    end
    e.pc    = m_pc;
    e.flush = m_flush;
    e.cnt   = m_cnt;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall = 1'b0; pc_src = 1'b1; branch_pc = 32'h80; branch_offset = 32'h4;
    model_reset();
    #2;
    n_tests++;
    if ({pc, flush, taken_count} !== {RESET_PC, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_async: got pc=%h flush=%b cnt=%0d, want pc=%h flush=0 cnt=0",
               pc, flush, taken_count, RESET_PC);
    end
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if ({pc, flush, taken_count} !== {RESET_PC, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_hold: got pc=%h flush=%b cnt=%0d, want pc=%h flush=0 cnt=0",
               pc, flush, taken_count, RESET_PC);
    end
    pc_src = 1'b0;
    reset  = 1'b0;
  endtask

  task automatic test_sequential();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0);
      e = sb.pop_front();
      n_tests++;
      if ({pc, flush, taken_count} !== e || pc !== 32'(4 * (i + 1))) begin
        n_fail++;
        $display("FAIL seq[%0d]: got pc=%h flush=%b cnt=%0d, want pc=%h flush=%b cnt=%0d",
                 i, pc, flush, taken_count, e.pc, e.flush, e.cnt);
      end
    end
    // Stalled RUN holds everything.
    drive_cycle(1'b1, 1'b0, 32'h0, 32'h0);
    e = sb.pop_front();
    n_tests++;
    if ({pc, flush, taken_count} !== e) begin
      n_fail++;
      $display("FAIL run_stall: got pc=%h flush=%b cnt=%0d, want pc=%h flush=%b cnt=%0d",
               pc, flush, taken_count, e.pc, e.flush, e.cnt);
    end
  endtask

  task automatic test_branch();
    exp_t e;
    // Walk pc from 0x10 up to 0x20.
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0);
      e = sb.pop_front();
    end
    n_tests++;
    if (pc !== 32'h20) begin
      n_fail++;
      $display("FAIL branch_setup: got pc=%h, want pc=00000020", pc);
    end
    drive_cycle(1'b0, 1'b1, 32'h18, 32'hFFFF_FFFE);
    e = sb.pop_front();
    n_tests++;
    if ({pc, flush, taken_count} !== e || pc !== 32'h14) begin
      n_fail++;
      $display("FAIL branch_redirect: got pc=%h flush=%b cnt=%0d, want pc=%h flush=%b cnt=%0d",
               pc, flush, taken_count, e.pc, e.flush, e.cnt);
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 32'h0);
    e = sb.pop_front();
    n_tests++;
    if ({pc, flush, taken_count} !== e || pc !== 32'h18) begin
      n_fail++;
      $display("FAIL branch_after: got pc=%h flush=%b cnt=%0d, want pc=%h flush=%b cnt=%0d",
               pc, flush, taken_count, e.pc, e.flush, e.cnt);
    end
  endtask

  task automatic test_stall_branch();
    exp_t e;
    drive_cycle(1'b1, 1'b1, 32'h200, 32'h8);  // target 0x224, branch wins over stall
    for (int i = 0; i < 4; i++) begin
      if (i > 0) drive_cycle(1'b1, 1'b0, 32'h0, 32'h0);
      e = sb.pop_front();
      n_tests++;
      if ({pc, flush, taken_count} !== e || pc !== 32'h224 || flush !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_flush[%0d]: got pc=%h flush=%b cnt=%0d, want pc=%h flush=%b cnt=%0d",
                 i, pc, flush, taken_count, e.pc, e.flush, e.cnt);
      end
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 32'h0);
    e = sb.pop_front();
    n_tests++;
    if ({pc, flush, taken_count} !== e || pc !== 32'h228) begin
      n_fail++;
      $display("FAIL stall_release: got pc=%h flush=%b cnt=%0d, want pc=%h flush=%b cnt=%0d",
               pc, flush, taken_count, e.pc, e.flush, e.cnt);
    end
  endtask

  task automatic test_flush_ignore();
    exp_t e;
    drive_cycle(1'b0, 1'b1, 32'h300, 32'h0);  // target 0x304
    e = sb.pop_front();
    drive_cycle(1'b0, 1'b1, 32'h100, 32'h10); // in FLUSH: must be ignored
    e = sb.pop_front();
    n_tests++;
    if ({pc, flush, taken_count} !== e || pc !== 32'h308 || taken_count !== 2'd3) begin
      n_fail++;
      $display("FAIL flush_ignore: got pc=%h flush=%b cnt=%0d, want pc=%h flush=%b cnt=%0d",
               pc, flush, taken_count, e.pc, e.flush, e.cnt);
    end
  endtask

  task automatic test_reset_midflush();
    exp_t e;
    drive_cycle(1'b1, 1'b1, 32'h400, 32'h0);
    e = sb.pop_front();
    drive_cycle(1'b1, 1'b0, 32'h0, 32'h0);
    e = sb.pop_front();
    // Pulse reset between edges while in FLUSH.
    reset = 1'b1;
    #2;
    n_tests++;
    if ({pc, flush, taken_count} !== {RESET_PC, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_midflush: got pc=%h flush=%b cnt=%0d, want pc=%h flush=0 cnt=0",
               pc, flush, taken_count, RESET_PC);
    end
    #2;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0);
      e = sb.pop_front();
      n_tests++;
      if ({pc, flush, taken_count} !== e || pc !== RESET_PC + 32'(4 * (i + 1))) begin
        n_fail++;
        $display("FAIL post_reset[%0d]: got pc=%h flush=%b cnt=%0d, want pc=%h flush=%b cnt=%0d",
                 i, pc, flush, taken_count, e.pc, e.flush, e.cnt);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [1:0] want_cnt [5];
    want_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 1'b1, 32'h40 * i, 32'h1);
      e = sb.pop_front();
      n_tests++;
      if ({pc, flush, taken_count} !== e || taken_count !== want_cnt[i]) begin
        n_fail++;
        $display("FAIL sat[%0d]: got pc=%h flush=%b cnt=%0d, want pc=%h flush=%b cnt=%0d",
                 i, pc, flush, taken_count, e.pc, e.flush, e.cnt);
      end
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0);
      e = sb.pop_front();
    end
    // Branch to 0xFFFF_FFF4, then step through 0xFFFF_FFFC and wrap to 0.
    drive_cycle(1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0);
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0);
      e = sb.pop_front();
    end
    n_tests++;
    if ({pc, flush, taken_count} !== e || pc !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wrap: got pc=%h flush=%b cnt=%0d, want pc=%h flush=%b cnt=%0d",
               pc, flush, taken_count, e.pc, e.flush, e.cnt);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; pc_src = 1'b0; branch_pc = '0; branch_offset = '0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall_branch();
    test_flush_ignore();
    test_reset_midflush();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be 00.
REQ-002 Parameter COUNT_W, default 16, width of the taken-branch counter.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc_src  input  1  registered branch-taken decision (branch AND alu zero); 1 = redirect fetch.
REQ-006 branch_pc  input  32  address of the branch instruction that produced pc_src, valid when pc_src=1.
REQ-007 branch_offset  input  32  sign-extended word offset of that branch, valid when pc_src=1.
REQ-008 stall  input  1  1 = hold fetch address this cycle.
REQ-009 pc  output  32  current fetch address, registered.
REQ-010 flush  output  1  registered; 1 = instruction fetched on the wrong path is to be squashed.
REQ-011 taken_count  output  COUNT_W  saturating count of accepted taken branches, registered.

Function
REQ-012 Block SHALL contain a two-state FSM: RUN, FLUSH.
REQ-013 Branch target SHALL be branch_pc + 4 + (branch_offset << 2), computed modulo 2^32, with bits [1:0] forced to 00.
REQ-014 Sequential increment SHALL be pc + 4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-015 RUN, pc_src=1: pc <= target, state <= FLUSH, flush <= 1, taken_count increments; applies regardless of stall (branch wins over stall).
REQ-016 RUN, pc_src=0, stall=1: pc, state, flush(=0), taken_count hold.
REQ-017 RUN, pc_src=0, stall=0: pc <= pc + 4, flush <= 0, state stays RUN.
REQ-018 FLUSH, stall=0: pc <= pc + 4, flush <= 0, state <= RUN.
REQ-019 FLUSH, stall=1: pc holds, flush stays 1, state stays FLUSH.
REQ-020 FLUSH: pc_src SHALL be ignored (decision belongs to a squashed instruction); taken_count SHALL NOT increment.
REQ-021 Redirect latency: pc SHALL show the target on the first rising edge after pc_src=1 is sampled in RUN; flush is high for exactly the following cycle when stall=0.
REQ-022 taken_count SHALL saturate at 2^COUNT_W - 1 and never wrap.
REQ-023 flush SHALL be 1 exactly when state is FLUSH.

Reset
REQ-024 reset=1 SHALL immediately, without a clock edge, force pc=RESET_PC, flush=0, taken_count=0, state=RUN.
REQ-025 reset asserted mid-FLUSH or mid-stall SHALL abandon the pending redirect/flush; first post-reset edge with stall=0, pc_src=0 yields pc=RESET_PC+4.
REQ-026 Outputs SHALL hold reset values while reset=1 irrespective of clock and inputs.

Verification
REQ-027 Reset, then 4 edges stall=0 pc_src=0 -> pc sequence 0x0,0x4,0x8,0xC,0x10; flush=0; taken_count=0.
REQ-028 RUN, pc=0x20, pc_src=1, branch_pc=0x18, branch_offset=0xFFFF_FFFE -> next pc=0x14, flush=1, taken_count=1; next edge (stall=0) pc=0x18, flush=0.
REQ-029 pc_src=1 and stall=1 in RUN -> redirect taken; then FLUSH with stall=1 for 3 edges -> pc holds target, flush=1 throughout; stall=0 -> pc=target+4, flush=0.
REQ-030 pc_src=1 during FLUSH (branch_pc=0x100, offset=0x10) -> ignored: pc=previous+4, taken_count unchanged.
REQ-031 COUNT_W=2, 5 accepted taken branches -> taken_count 1,2,3,3,3; pc=0xFFFF_FFFC, stall=0 -> pc=0x0.
REQ-032 reset pulsed asynchronously between edges while in FLUSH -> pc=RESET_PC and flush=0 before next edge; normal sequencing resumes.
